// File: rtl/uart_word_serializer.sv
// Sends a DATA_WIDTH-bit word as DATA_WIDTH/8 LSB-first UART frames, least significant byte first.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits of every frame.
module uart_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  tx_out
);

  localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD;
  localparam int NUM_BYTES      = DATA_WIDTH / 8;
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BYTE_W         = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      baud_reg,  baud_next;
  logic [2:0]            bit_reg,   bit_next;
  logic [BYTE_W-1:0]     byte_reg,  byte_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  tx_reg,    tx_next;
  logic                  busy_reg,  busy_next;
  logic                  done_reg,  done_next;

  logic       bit_end;
  logic [2:0] bit_inc;

  assign bit_end = (baud_reg == CNT_LAST);
  assign bit_inc = bit_reg + 3'd1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // tx_next always carries the level of the bit the next state transmits,
  // so the line is a pure flop output and changes exactly on bit boundaries.
  always_comb begin
    state_next = state_reg;
    baud_next  = '0;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    if (state_reg != IDLE && !bit_end) begin
      baud_next = baud_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (ready_in) begin
          state_next = START;
          shift_next = data_in;
          byte_next  = '0;
          bit_next   = '0;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = ^shift_reg[7:0];
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_next = bit_inc;
            tx_next  = shift_reg[bit_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (byte_reg == BYTE_LAST) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            tx_next    = 1'b1;
          end else begin
            // Next byte starts with no idle gap.
            state_next = START;
            byte_next  = byte_reg + BYTE_W'(1);
            shift_next = shift_reg >> 8;
            tx_next    = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx_out   = tx_reg;
  assign busy_out = busy_reg;
  assign done_out = done_reg;

endmodule

// File: tb/tb_uart_word_serializer.sv
// Self-checking bench for uart_word_serializer: table of known words plus random words,
// each compared cycle-by-cycle against an arithmetic line model and decoded by a UART receiver model.
module tb_uart_word_serializer;

  localparam int DW   = 32;
  localparam int CF   = 1600;
  localparam int BD   = 100;
  localparam int CPB  = CF / BD;
`ifdef UART_TX_PARITY_EN
  localparam int F    = 11;
`else
  localparam int F    = 10;
`endif
  localparam int NB    = DW / 8;
  localparam int TOTAL = NB * F * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] data = '0;
  logic          busy, done, tx;

  int checks = 0;
  int errors = 0;
  logic line [TOTAL];

  uart_word_serializer #(.DATA_WIDTH(DW), .CLK_FREQ(CF), .BAUD(BD)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .ready_in (ready),
    .data_in  (data),
    .busy_out (busy),
    .done_out (done),
    .tx_out   (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] seq;     // expected bytes in line order, first byte in [31:24]
    int          ign_at;  // busy-cycle index for an ignored ready_in, -1 for none
    bit          chain;   // next entry is started on this word's done cycle
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Line level during frame-bit n of a word, from the framing rules.
  function automatic logic model_bit(input logic [31:0] w, input int n);
    int fr = n / F;
    int pos = n % F;
    logic [7:0] b = w[fr*8 +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (F == 11 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic accept(input logic [31:0] w);
    @(posedge clk); #1;
    ready = 1'b1;
    data  = w;
    @(posedge clk); #1;
    ready = 1'b0;
    data  = $urandom;
  endtask

  // Called just after the acceptance edge; checks the whole transfer and the done cycle.
  task automatic check_word(input logic [31:0] w, input int ign_at, input bit chain,
                            input logic [31:0] next_w, output logic [31:0] seq);
    int bad = 0;
    int busy_bad = 0;
    int frame_bad = 0;
    int edge_bad = 0;
    logic [7:0] b;
    for (int k = 0; k < TOTAL; k++) begin
      @(negedge clk);
      line[k] = tx;
      if (tx !== model_bit(w, k / CPB)) bad++;
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      if (k == ign_at) begin
        ready = 1'b1;
        data  = 32'hFFFF_FFFF;
      end else if (k == ign_at + 1) begin
        ready = 1'b0;
      end
    end
    check("wave", bad, 0);
    check("busy_during", busy_bad, 0);
    seq = '0;
    for (int by = 0; by < NB; by++) begin
      if (line[by*F*CPB + CPB/2] !== 1'b0) frame_bad++;
      if (line[(by*F + F - 1)*CPB + CPB/2] !== 1'b1) frame_bad++;
      for (int i = 0; i < 8; i++) b[i] = line[(by*F + 1 + i)*CPB + CPB/2];
      seq = {seq[23:0], b};
    end
    check("framing", frame_bad, 0);
    for (int k = 1; k < TOTAL; k++)
      if (line[k] !== line[k-1] && (k % CPB) != 0) edge_bad++;
    check("edges", edge_bad, 0);
    @(posedge clk); #1;
    if (chain) begin
      ready = 1'b1;
      data  = next_w;
    end
    @(negedge clk);
    check("done_pulse", {busy, done, tx}, 3'b011);
    if (chain) begin
      @(posedge clk); #1;
      ready = 1'b0;
      data  = $urandom;
    end else begin
      @(negedge clk);
      check("done_clear", {busy, done, tx}, 3'b001);
    end
  endtask

  initial begin
    vec_t vecs[6];
    logic [31:0] seq, next_w, w;
    bit pre;
    int bad;

    vecs[0] = '{32'hA5C3_0F81, 32'h810F_C3A5, -1, 1'b0};
    vecs[1] = '{32'h0000_0055, 32'h5500_0000, -1, 1'b0};
    vecs[2] = '{32'h1234_5678, 32'h7856_3412, 200, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, -1, 1'b1};
    vecs[4] = '{32'hDEAD_BEEF, 32'hEFBE_ADDE, -1, 1'b0};
    vecs[5] = '{32'h0F1E_2D3C, 32'h3C2D_1E0F, -1, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset", {busy, done, tx}, 3'b001);
    bad = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if ({busy, done, tx} !== 3'b001) bad++;
    end
    check("idle_line", bad, 0);

    pre = 1'b0;
    for (int i = 0; i < 6; i++) begin
      next_w = '0;
      if (vecs[i].chain) next_w = vecs[i+1].word;
      if (!pre) accept(vecs[i].word);
      check_word(vecs[i].word, vecs[i].ign_at, vecs[i].chain, next_w, seq);
      check("bytes", seq, vecs[i].seq);
      $display("word %08h sent as %08h", vecs[i].word, seq);
      pre = vecs[i].chain;
    end

    accept(32'h1234_5678);
    repeat ((F + 4) * CPB) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset", {busy, done, tx}, 3'b001);
    bad = 0;
    for (int k = 0; k < 3 * CPB; k++) begin
      @(negedge clk);
      if ({busy, done, tx} !== 3'b001) bad++;
    end
    check("post_reset_quiet", bad, 0);
    accept(32'h0000_0001);
    check_word(32'h0000_0001, -1, 1'b0, '0, seq);
    check("after_reset_bytes", seq, 32'h0100_0000);
    $display("word 00000001 after reset sent as %08h", seq);

    for (int r = 0; r < 15; r++) begin
      w = $urandom;
      accept(w);
      check_word(w, -1, 1'b0, '0, seq);
      check("rand_bytes", seq, {w[7:0], w[15:8], w[23:16], w[31:24]});
      $display("random word %08h sent as %08h", w, seq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
